// File: rtl/seg7_scan_driver_if.sv
// Pin-side bundle for the 4-digit seven-segment scan driver.
// The master supplies the value/dp/enable requests; the slave (the driver)
// returns the active-low display pins and the frame tick.
interface seg7_scan_driver_if;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic [7:0]  io_seg;
    logic [3:0]  io_sel;
    logic        scan_tick;

    modport master (
        output value,
        output dp,
        output digit_en,
        input  io_seg,
        input  io_sel,
        input  scan_tick
    );

    modport slave (
        input  value,
        input  dp,
        input  digit_en,
        output io_seg,
        output io_sel,
        output scan_tick
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-select seven-segment display.
// Each digit owns a slot of 2^DIV_BITS cycles; the first BLANK_CYCLES of every
// slot keep all segments and selects off to avoid ghosting, then the digit's
// nibble, decimal point and enable are sampled once and held to slot end.
// All pin outputs are registered and active-low.
module seg7_scan_driver #(
    parameter int DIV_BITS     = 16,
    parameter int BLANK_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    seg7_scan_driver_if.slave   bus
);

    localparam logic [DIV_BITS-1:0] CNT_MAX  = {DIV_BITS{1'b1}};
    localparam logic [DIV_BITS-1:0] CNT_ONE  = {{(DIV_BITS-1){1'b0}}, 1'b1};
    localparam logic [DIV_BITS-1:0] DRIVE_AT = DIV_BITS'(BLANK_CYCLES - 1);
    localparam logic [7:0]          SEG_OFF  = 8'hFF;
    localparam logic [3:0]          SEL_OFF  = 4'hF;

    logic [DIV_BITS-1:0] cnt_q, cnt_d;
    logic [1:0]          idx_q, idx_d;
    logic [7:0]          seg_q, seg_d;
    logic [3:0]          sel_q, sel_d;
    logic                tick_q, tick_d;
    logic [3:0]          nibble;

    // Active-low a..g pattern for one hex digit (bit0=a .. bit6=g).
    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Next-state: slot counter, digit index, blank/drive output updates and frame tick.
    always_comb begin
        cnt_d  = cnt_q + CNT_ONE;
        idx_d  = idx_q;
        seg_d  = seg_q;
        sel_d  = sel_q;
        tick_d = 1'b0;
        nibble = bus.value[{idx_q, 2'b00} +: 4];
        if (cnt_q == CNT_MAX) begin
            // Slot end: move to the next digit and start its blank window.
            idx_d  = idx_q + 2'd1;
            seg_d  = SEG_OFF;
            sel_d  = SEL_OFF;
            tick_d = (idx_q == 2'd3);
        end else if (cnt_q == DRIVE_AT) begin
            // Blank window over: sample this digit's request and hold it.
            if (bus.digit_en[idx_q]) begin
                seg_d = {~bus.dp[idx_q], hex7(nibble)};
                sel_d = ~(4'b0001 << idx_q);
            end else begin
                seg_d = SEG_OFF;
                sel_d = SEL_OFF;
            end
        end
    end

    // State and pin registers; reset aborts any slot in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            idx_q  <= 2'd0;
            seg_q  <= SEG_OFF;
            sel_q  <= SEL_OFF;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            seg_q  <= seg_d;
            sel_q  <= sel_d;
            tick_q <= tick_d;
        end
    end

    assign bus.io_seg    = seg_q;
    assign bus.io_sel    = sel_q;
    assign bus.scan_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a 16-cycle slot (DIV_BITS=4,
// BLANK_CYCLES=2). Inputs change on the falling edge; outputs are sampled there.
module tb_seg7_scan_driver;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    seg7_scan_driver_if bus_if ();

    seg7_scan_driver #(
        .DIV_BITS     (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Hold reset for n edges, checking dark pins and no tick, then release.
    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            step();
            chk("rst_seg", 32'(bus_if.io_seg), 32'hFF);
            chk("rst_sel", 32'(bus_if.io_sel), 32'hF);
            chk("rst_tick", 32'(bus_if.scan_tick), 32'h0);
        end
        rst_n = 1'b1;
    endtask

    // Called at slot cycle 0; checks all 16 cycles and ends at next slot's cycle 0.
    task automatic check_slot(input string tag, input logic [7:0] eseg, input logic [3:0] esel);
        for (int i = 0; i < 16; i++) begin
            if (i < 2) begin
                chk({tag, "_blank_seg"}, 32'(bus_if.io_seg), 32'hFF);
                chk({tag, "_blank_sel"}, 32'(bus_if.io_sel), 32'hF);
            end else begin
                chk({tag, "_seg"}, 32'(bus_if.io_seg), 32'(eseg));
                chk({tag, "_sel"}, 32'(bus_if.io_sel), 32'(esel));
            end
            step();
        end
    endtask

    initial begin
        int ticks;
        n_checks = 0;
        n_errors = 0;
        bus_if.value    = 16'h1234;
        bus_if.dp       = 4'b0000;
        bus_if.digit_en = 4'hF;
        rst_n           = 1'b0;
        @(negedge clk);

        // 1: reset then first two digits of 1234
        do_reset(5);
        check_slot("s1_d0", 8'h99, 4'hE);
        check_slot("s1_d1", 8'hB0, 4'hD);

        // 2: full frame of ABCD with dp on digits 0 and 2
        do_reset(1);
        bus_if.value = 16'hABCD;
        bus_if.dp    = 4'b0101;
        check_slot("s2_d0", 8'h21, 4'hE);
        check_slot("s2_d1", 8'hC6, 4'hD);
        check_slot("s2_d2", 8'h03, 4'hB);
        check_slot("s2_d3", 8'h88, 4'h7);

        // 3: digit 2 disabled stays dark
        bus_if.digit_en = 4'b1011;
        check_slot("s3_d0", 8'h21, 4'hE);
        check_slot("s3_d1", 8'hC6, 4'hD);
        check_slot("s3_d2", 8'hFF, 4'hF);
        check_slot("s3_d3", 8'h88, 4'h7);

        // 4: value change mid digit-1 slot only shows on its next slot
        bus_if.value    = 16'h0000;
        bus_if.dp       = 4'b0000;
        bus_if.digit_en = 4'hF;
        check_slot("s4_d0", 8'hC0, 4'hE);
        for (int i = 0; i < 16; i++) begin
            if (i < 2) begin
                chk("s4_d1_blank_seg", 32'(bus_if.io_seg), 32'hFF);
                chk("s4_d1_blank_sel", 32'(bus_if.io_sel), 32'hF);
            end else begin
                chk("s4_d1_hold_seg", 32'(bus_if.io_seg), 32'hC0);
                chk("s4_d1_hold_sel", 32'(bus_if.io_sel), 32'hD);
            end
            if (i == 5) bus_if.value = 16'hFFFF;
            step();
        end
        check_slot("s4_d2", 8'h8E, 4'hB);
        check_slot("s4_d3", 8'h8E, 4'h7);
        check_slot("s4_d0b", 8'h8E, 4'hE);
        check_slot("s4_d1b", 8'h8E, 4'hD);

        // 5: three frames give three single-cycle ticks 64 cycles apart
        do_reset(1);
        ticks = 0;
        for (int t = 0; t <= 192; t++) begin
            chk("s5_tick", 32'(bus_if.scan_tick), (t > 0 && t % 64 == 0) ? 32'h1 : 32'h0);
            if (bus_if.scan_tick) ticks++;
            if (t < 192) step();
        end
        chk("s5_tick_count", 32'(ticks), 32'd3);

        // 6: one-cycle reset during digit 2 drive restarts the scan
        bus_if.value = 16'h1234;
        do_reset(1);
        for (int t = 0; t < 37; t++) step();
        chk("s6_pre_sel", 32'(bus_if.io_sel), 32'hB);
        chk("s6_pre_seg", 32'(bus_if.io_seg), 32'hA4);
        rst_n = 1'b0;
        step();
        chk("s6_rst_seg", 32'(bus_if.io_seg), 32'hFF);
        chk("s6_rst_sel", 32'(bus_if.io_sel), 32'hF);
        chk("s6_rst_idx", 32'(dut.idx_q), 32'h0);
        rst_n = 1'b1;
        check_slot("s6_d0", 8'h99, 4'hE);
        check_slot("s6_d1", 8'hB0, 4'hD);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
